darkbus_arbiter: RTL and testbench

- Sequences and shares one single-port synchronous data RAM between two requesters: the darkriscv core data port (DAS/DRD/DWR/DADDR/DATAO/DLEN) and a secondary bus master (X port, used by DMA or a testbench backdoor).
- Generates the core's HLT wait states and the memory byte enables.
- Runs a round-robin arbiter with a latency-counting FSM.
- Sits between core0 and the data memory in the SoC/sim top.

---
 rtl/darkbus_arbiter.sv | 152 +++++++++++++++
 tb/tb_darkbus_arbiter.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/darkbus_arbiter.sv
// darkbus_arbiter: shares one single-port synchronous data RAM between the
// darkriscv core data port and a secondary (X) bus master. Round-robin grant
// in IDLE; reads hold the FSM for MEM_LAT cycles while the RAM returns data.
// Ports:
//   i_clk, i_res          clock (rising edge), synchronous active-high reset
//   i_c_*                 core data port request (DAS/DRD/DWR/DADDR/DATAO/DLEN)
//   o_c_datai, o_c_hlt    core read data and stall
//   i_x_*                 secondary request (held stable until o_x_gnt)
//   o_x_gnt, o_x_ack      issue pulse and completion pulse
//   o_x_rdata             secondary read data, held after o_x_ack
//   o_m_*, i_m_rdata      RAM strobe/write/word address/data/byte enables
module darkbus_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          i_clk,
  input  logic          i_res,
  input  logic          i_c_das,
  input  logic          i_c_drd,
  input  logic          i_c_dwr,
  input  logic [AW-1:0] i_c_daddr,
  input  logic [DW-1:0] i_c_datao,
  input  logic [2:0]    i_c_dlen,
  output logic [DW-1:0] o_c_datai,
  output logic          o_c_hlt,
  input  logic          i_x_req,
  input  logic          i_x_wr,
  input  logic [AW-1:0] i_x_addr,
  input  logic [DW-1:0] i_x_wdata,
  input  logic [3:0]    i_x_be,
  output logic          o_x_gnt,
  output logic          o_x_ack,
  output logic [DW-1:0] o_x_rdata,
  output logic          o_m_en,
  output logic          o_m_we,
  output logic [AW-1:0] o_m_addr,
  output logic [DW-1:0] o_m_wdata,
  output logic [3:0]    o_m_be,
  input  logic [DW-1:0] i_m_rdata
);

  localparam logic [2:0] LAT = 3'(MEM_LAT);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_C_RD = 2'd1,
    S_X_RD = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_next;
  logic [2:0]    r_lat_cnt;
  logic          r_last_x;     // 1: most recent grant went to the X port
  logic [DW-1:0] r_c_hold;
  logic [DW-1:0] r_x_rdata;

  logic          w_creq;
  logic          w_c_wr;
  logic          w_idle;
  logic          w_done;
  logic          w_c_done;
  logic          w_x_done;
  logic          w_gnt_c;
  logic          w_gnt_x;
  logic [3:0]    w_c_be;

  // A core strobe with both DRD and DWR set is treated as a write.
  assign w_creq = i_c_das & (i_c_drd | i_c_dwr);
  assign w_c_wr = i_c_dwr;
  assign w_idle = (r_state == S_IDLE);

  // Every decision is gated by reset so the forced-output behaviour falls out
  // of the normal equations rather than a separate override.
  assign w_done   = ~i_res & ~w_idle & (r_lat_cnt == LAT);
  assign w_c_done = w_done & (r_state == S_C_RD);
  assign w_x_done = w_done & (r_state == S_X_RD);

  // On a tie the requester that did not win last time goes first.
  assign w_gnt_c = ~i_res & w_idle & w_creq  & (~i_x_req | r_last_x);
  assign w_gnt_x = ~i_res & w_idle & i_x_req & (~w_creq  | ~r_last_x);

  // Misaligned core accesses simply align down inside the word.
  always_comb begin
    w_c_be = 4'b0000;
    if (i_c_dlen[2])      w_c_be = 4'b1111;
    else if (i_c_dlen[1]) w_c_be = 4'b0011 << {i_c_daddr[1], 1'b0};
    else if (i_c_dlen[0]) w_c_be = 4'b0001 << i_c_daddr[1:0];
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_gnt_c && !w_c_wr)      w_state_next = S_C_RD;
        else if (w_gnt_x && !i_x_wr) w_state_next = S_X_RD;
      end
      S_C_RD, S_X_RD: begin
        if (w_done) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // With no grant the RAM bus idles on the core's fields (don't-care values).
  always_comb begin
    o_m_en    = 1'b0;
    o_m_we    = 1'b0;
    o_m_addr  = {i_c_daddr[AW-1:2], 2'b00};
    o_m_wdata = i_c_datao;
    o_m_be    = w_c_be;
    if (w_gnt_x) begin
      o_m_en    = 1'b1;
      o_m_we    = i_x_wr;
      o_m_addr  = {i_x_addr[AW-1:2], 2'b00};
      o_m_wdata = i_x_wdata;
      o_m_be    = i_x_be;
    end else if (w_gnt_c) begin
      o_m_en = 1'b1;
      o_m_we = w_c_wr;
    end
  end

  // The core stalls whenever it asks and is not being served this cycle:
  // a granted write and the completion of its own read are the only releases.
  assign o_c_hlt   = w_creq & ~i_res & ~(w_gnt_c & w_c_wr) & ~w_c_done;
  assign o_c_datai = w_c_done ? i_m_rdata : r_c_hold;
  assign o_x_gnt   = w_gnt_x;
  assign o_x_ack   = (w_gnt_x & i_x_wr) | w_x_done;
  assign o_x_rdata = w_x_done ? i_m_rdata : r_x_rdata;

  always_ff @(posedge i_clk) begin
    if (i_res) begin
      r_state   <= S_IDLE;
      r_lat_cnt <= 3'd0;
      r_last_x  <= 1'b1;
      r_c_hold  <= '0;
      r_x_rdata <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_state_next != S_IDLE && w_idle)
        r_lat_cnt <= 3'd1;
      else if (!w_idle)
        r_lat_cnt <= w_done ? 3'd0 : r_lat_cnt + 3'd1;
      if (w_gnt_c)      r_last_x <= 1'b0;
      else if (w_gnt_x) r_last_x <= 1'b1;
      if (w_c_done) r_c_hold  <= i_m_rdata;
      if (w_x_done) r_x_rdata <= i_m_rdata;
    end
  end

endmodule

// File: tb/tb_darkbus_arbiter.sv
module tb_darkbus_arbiter;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 3;

  logic          clk = 1'b0;
  logic          res;
  logic          c_das, c_drd, c_dwr;
  logic [31:0]   c_daddr, c_datao, c_datai;
  logic [2:0]    c_dlen;
  logic          c_hlt;
  logic          x_req, x_wr, x_gnt, x_ack;
  logic [31:0]   x_addr, x_wdata, x_rdata;
  logic [3:0]    x_be;
  logic          m_en, m_we;
  logic [31:0]   m_addr, m_wdata, m_rdata;
  logic [3:0]    m_be;

  darkbus_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .i_clk(clk), .i_res(res),
    .i_c_das(c_das), .i_c_drd(c_drd), .i_c_dwr(c_dwr),
    .i_c_daddr(c_daddr), .i_c_datao(c_datao), .i_c_dlen(c_dlen),
    .o_c_datai(c_datai), .o_c_hlt(c_hlt),
    .i_x_req(x_req), .i_x_wr(x_wr), .i_x_addr(x_addr),
    .i_x_wdata(x_wdata), .i_x_be(x_be),
    .o_x_gnt(x_gnt), .o_x_ack(x_ack), .o_x_rdata(x_rdata),
    .o_m_en(m_en), .o_m_we(m_we), .o_m_addr(m_addr),
    .o_m_wdata(m_wdata), .o_m_be(m_be), .i_m_rdata(m_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- RAM environment (latency LAT) ----------------
  logic [31:0] ram [0:255];
  logic [31:0] rd_pipe [1:LAT];

  always @(posedge clk) begin
    if (m_en && m_we)
      for (int b = 0; b < 4; b++)
        if (m_be[b]) ram[m_addr[9:2]][b*8 +: 8] <= m_wdata[b*8 +: 8];
    rd_pipe[1] <= (m_en && !m_we) ? ram[m_addr[9:2]] : 32'h0BAD0BAD;
    for (int k = 2; k <= LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
  end
  assign m_rdata = rd_pipe[LAT];

  // ---------------- Behavioural reference model ----------------
  // Tracks who owns the RAM and the cycle number at which that read finishes,
  // plus its own copy of memory contents to predict returned data.
  logic [31:0] mm [0:255];
  int          own     = 0;      // 0 none, 1 core, 2 X
  int          last    = 2;      // last grant: 1 core, 2 X
  int          cyc     = 0;
  int          done_at = 0;
  logic [31:0] pend    = 0;
  logic [31:0] mc_hold = 0;
  logic [31:0] mx_rd   = 0;

  function automatic logic [3:0] core_be(input logic [31:0] a, input logic [2:0] len);
    int off;
    off = int'(a % 32'd4);
    if (len[2]) return 4'hF;
    if (len[1]) return 4'(3 << ((off / 2) * 2));
    if (len[0]) return 4'(1 << off);
    return 4'h0;
  endfunction

  int          win;
  logic        creq, comp, e_we, e_hlt, e_ack;
  logic [31:0] e_addr, e_wdata, e_cd, e_xd;
  logic [3:0]  e_be;

  always @(negedge clk) begin
    cyc++;
    if (res) begin
      chk("rst c_hlt", c_hlt, 0);
      chk("rst m_en", m_en, 0);
      chk("rst m_we", m_we, 0);
      chk("rst x_gnt", x_gnt, 0);
      chk("rst x_ack", x_ack, 0);
      chk("rst c_datai", c_datai, mc_hold);
      chk("rst x_rdata", x_rdata, mx_rd);
      own = 0; last = 2; mc_hold = 0; mx_rd = 0;
    end else begin
      creq = c_das & (c_drd | c_dwr);
      comp = (own != 0) && (cyc == done_at);
      win  = 0;
      if (own == 0) begin
        if (creq && x_req) win = (last == 2) ? 1 : 2;
        else if (creq)     win = 1;
        else if (x_req)    win = 2;
      end
      e_we    = (win == 1) ? c_dwr : (win == 2) ? x_wr : 1'b0;
      e_addr  = (win == 2) ? {x_addr[31:2], 2'b00} : {c_daddr[31:2], 2'b00};
      e_wdata = (win == 2) ? x_wdata : c_datao;
      e_be    = (win == 2) ? x_be : core_be(c_daddr, c_dlen);
      e_hlt   = creq && !(win == 1 && c_dwr) && !(own == 1 && comp);
      e_cd    = (own == 1 && comp) ? pend : mc_hold;
      e_xd    = (own == 2 && comp) ? pend : mx_rd;
      e_ack   = (win == 2 && x_wr) || (own == 2 && comp);

      chk("m_en", m_en, (win != 0));
      chk("m_we", m_we, e_we);
      chk("m_addr", m_addr, e_addr);
      chk("m_wdata", m_wdata, e_wdata);
      chk("m_be", m_be, e_be);
      chk("c_hlt", c_hlt, e_hlt);
      chk("c_datai", c_datai, e_cd);
      chk("x_gnt", x_gnt, (win == 2));
      chk("x_ack", x_ack, e_ack);
      chk("x_rdata", x_rdata, e_xd);

      if (comp) begin
        if (own == 1) mc_hold = pend; else mx_rd = pend;
        own = 0;
      end
      if (win != 0) begin
        last = win;
        if (e_we) begin
          for (int b = 0; b < 4; b++)
            if (e_be[b]) mm[e_addr[9:2]][b*8 +: 8] = e_wdata[b*8 +: 8];
        end else begin
          own     = win;
          done_at = cyc + LAT;
          pend    = mm[e_addr[9:2]];
        end
      end
    end
  end

  // ---------------- Stimulus ----------------
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_core();
    c_das = 1'b0; c_drd = 1'b0; c_dwr = 1'b0;
  endtask

  task automatic wait_hlt_low(output int n);
    n = 0;
    while (c_hlt !== 1'b0 && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      checks++; errors++;
      $display("FAIL hlt_timeout: c_hlt still %b after %0d cycles, required 0", c_hlt, n);
    end
  endtask

  task automatic core_read(input logic [31:0] a, input string nm, input logic [31:0] expv);
    int n;
    tick();
    c_das = 1'b1; c_drd = 1'b1; c_dwr = 1'b0; c_daddr = a; c_dlen = 3'b100;
    @(negedge clk);
    wait_hlt_low(n);
    chk(nm, c_datai, expv);
    tick();
    idle_core();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, required finish before 100us");
    $fatal(1);
  end

  initial begin
    int n;
    int wcount;
    int hltc;
    res = 1'b1;
    c_das = 1'b1; c_drd = 1'b1; c_dwr = 1'b0; c_daddr = 32'h104; c_datao = 0; c_dlen = 3'b100;
    x_req = 1'b1; x_wr = 1'b1; x_addr = 32'h10; x_wdata = 0; x_be = 4'hF;
    for (int i = 0; i < 256; i++) begin ram[i] = 0; mm[i] = 0; end
    ram[8'h41] = 32'hDEADBEEF; mm[8'h41] = 32'hDEADBEEF;
    ram[8'hC0] = 32'hCAFEF00D; mm[8'hC0] = 32'hCAFEF00D;

    // Reset with both requesters active: everything must stay quiet.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset hlt forced", c_hlt, 0);
    chk("reset gnt forced", x_gnt, 0);
    chk("reset m_en forced", m_en, 0);
    chk("reset c_datai", c_datai, 0);
    chk("reset x_rdata", x_rdata, 0);
    tick();
    res = 1'b0; idle_core(); x_req = 1'b0;

    // Core word read: HLT for LAT cycles, data shows up as HLT falls.
    tick();
    c_das = 1'b1; c_drd = 1'b1; c_daddr = 32'h104; c_dlen = 3'b100;
    @(negedge clk);
    chk("rd m_en", m_en, 1);
    chk("rd m_addr", m_addr, 32'h104);
    chk("rd m_be", m_be, 4'hF);
    wait_hlt_low(n);
    chk("rd hlt cycles", n, LAT);
    chk("rd c_datai", c_datai, 32'hDEADBEEF);
    tick(); idle_core();
    @(negedge clk);
    chk("rd c_datai held", c_datai, 32'hDEADBEEF);

    // Sub-word core writes: byte, half, misaligned half.
    tick();
    c_das = 1'b1; c_dwr = 1'b1; c_daddr = 32'h203; c_datao = 32'hAB000000; c_dlen = 3'b001;
    @(negedge clk);
    chk("bw m_we", m_we, 1);
    chk("bw m_addr", m_addr, 32'h200);
    chk("bw m_be", m_be, 4'b1000);
    chk("bw hlt", c_hlt, 0);
    tick();
    c_daddr = 32'h202; c_datao = 32'h5A5A0000; c_dlen = 3'b010;
    @(negedge clk);
    chk("hw m_be", m_be, 4'b1100);
    tick();
    c_daddr = 32'h201; c_datao = 32'h00003C00; c_dlen = 3'b010;
    @(negedge clk);
    chk("hw misaligned m_be", m_be, 4'b0011);
    tick(); idle_core();

    // Tie after reset: core first, X waits until after core completion.
    tick(); res = 1'b1;
    tick(); tick(); res = 1'b0;
    tick();
    c_das = 1'b1; c_drd = 1'b1; c_dwr = 1'b0; c_daddr = 32'h104; c_dlen = 3'b100;
    x_req = 1'b1; x_wr = 1'b1; x_addr = 32'h10; x_wdata = 32'h12345678; x_be = 4'hF;
    @(negedge clk);
    chk("tie1 core wins", m_addr, 32'h104);
    chk("tie1 x_gnt", x_gnt, 0);
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); @(negedge clk);
      chk("tie1 x held off", x_gnt, 0);
    end
    chk("tie1 core done", c_hlt, 0);
    // Core immediately asks again: second tie goes to X.
    tick();
    c_drd = 1'b0; c_dwr = 1'b1; c_daddr = 32'h20; c_datao = 32'h11112222;
    @(negedge clk);
    chk("tie2 x_gnt", x_gnt, 1);
    chk("tie2 x_ack", x_ack, 1);
    chk("tie2 hlt", c_hlt, 1);
    chk("tie2 m_wdata", m_wdata, 32'h12345678);
    tick(); x_req = 1'b0;
    @(negedge clk);
    chk("tie2 core next", c_hlt, 0);
    chk("tie2 core addr", m_addr, 32'h20);
    tick(); idle_core();

    // X read with a core write queued behind it.
    tick();
    x_req = 1'b1; x_wr = 1'b0; x_addr = 32'h300;
    @(negedge clk);
    chk("xr gnt", x_gnt, 1);
    chk("xr m_we", m_we, 0);
    tick();
    x_req = 1'b0;
    c_das = 1'b1; c_dwr = 1'b1; c_drd = 1'b0; c_daddr = 32'h40; c_datao = 32'h77778888; c_dlen = 3'b100;
    @(negedge clk);
    chk("xr c1 hlt", c_hlt, 1);
    @(posedge clk); @(negedge clk);
    chk("xr c2 hlt", c_hlt, 1);
    chk("xr c2 ack", x_ack, 0);
    @(posedge clk); @(negedge clk);
    chk("xr c3 hlt", c_hlt, 1);
    chk("xr c3 ack", x_ack, 1);
    chk("xr c3 rdata", x_rdata, 32'hCAFEF00D);
    tick();
    @(negedge clk);
    chk("xr c4 hlt", c_hlt, 0);
    chk("xr c4 m_we", m_we, 1);
    tick(); idle_core();
    @(negedge clk);
    chk("xr rdata held", x_rdata, 32'hCAFEF00D);

    // Reset in the middle of an X read: abandoned, then a fresh read works.
    tick();
    x_req = 1'b1; x_wr = 1'b0; x_addr = 32'h300;
    @(negedge clk);
    chk("rr gnt", x_gnt, 1);
    tick(); x_req = 1'b0; res = 1'b1;
    @(negedge clk);
    chk("rr c1 ack", x_ack, 0);
    tick(); res = 1'b0; x_req = 1'b1; x_addr = 32'h104;
    @(negedge clk);
    chk("rr rdata cleared", x_rdata, 0);
    chk("rr idle regrant", x_gnt, 1);
    tick(); x_req = 1'b0;
    @(negedge clk);
    chk("rr no stale ack", x_ack, 0);
    n = 0;
    while (x_ack !== 1'b1 && n < 20) begin n++; @(negedge clk); end
    chk("rr ack latency", n + 1, LAT);
    chk("rr rdata", x_rdata, 32'hDEADBEEF);

    // Eight back-to-back core writes with no X traffic.
    wcount = 0; hltc = 0;
    for (int i = 0; i < 8; i++) begin
      tick();
      c_das = 1'b1; c_dwr = 1'b1; c_drd = 1'b0; c_dlen = 3'b100;
      c_daddr = 32'(32'h80 + 4 * i); c_datao = 32'(32'hA0000000 + i);
      @(negedge clk);
      if (m_en && m_we) wcount++;
      if (c_hlt) hltc++;
    end
    tick(); idle_core();
    chk("b2b writes", wcount, 8);
    chk("b2b hlt", hltc, 0);

    // Read back what the writes left in memory.
    core_read(32'h88,  "rb b2b",   32'hA0000002);
    core_read(32'h200, "rb lanes", 32'h5A5A3C00);
    core_read(32'h10,  "rb xwr",   32'h12345678);
    core_read(32'h20,  "rb cwr",   32'h11112222);
    core_read(32'h40,  "rb queued", 32'h77778888);

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
